// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_if_pkg
//  Description : Shared command codes, responder states, region codes and
//                the default program image for the memory bus target.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

   localparam logic [1:0] MEM_CMD_READ  = 2'b00;
   localparam logic [1:0] MEM_CMD_WRITE = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } resp_state_e;

   typedef enum logic [1:0] {
      REGION_ROM      = 2'd0,
      REGION_RAM      = 2'd1,
      REGION_UNMAPPED = 2'd2
   } region_e;

   localparam int ROM_DEFAULT_WORDS = 256;

   // Boot word at index 0, every other word tagged with its own index.
   function automatic logic [ROM_DEFAULT_WORDS*32-1:0] default_rom_image();
      logic [ROM_DEFAULT_WORDS*32-1:0] img;
      img = '0;
      for (int i = 0; i < ROM_DEFAULT_WORDS; i++) begin
         img[i*32 +: 32] = 32'hC0DE_0000 | 32'(i);
      end
      img[31:0] = 32'h1234_5678;
      return img;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_region_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_region_decoder
//  Description : Maps a word address onto the ROM / RAM / unmapped regions
//                and returns the word index inside the hit region.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_region_decoder
   import mem_if_pkg::*;
#(
   parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
   parameter int          ROM_WORDS = 256,
   parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
   parameter int          RAM_WORDS = 256,
   parameter int          IDX_W     = 8
) (
   input  logic [31:0]      i_addr,
   output region_e          o_region,
   output logic [IDX_W-1:0] o_word_index
);

   logic [32:0] w_rom_off;
   logic [32:0] w_ram_off;
   logic        w_rom_hit;
   logic        w_ram_hit;

   // 33-bit difference: the borrow bit flags addresses below the base, and
   // the exclusive upper bound stops any wrap into the array.
   assign w_rom_off = {1'b0, i_addr} - {1'b0, ROM_BASE};
   assign w_ram_off = {1'b0, i_addr} - {1'b0, RAM_BASE};
   assign w_rom_hit = !w_rom_off[32] && (w_rom_off[31:0] < 32'(ROM_WORDS));
   assign w_ram_hit = !w_ram_off[32] && (w_ram_off[31:0] < 32'(RAM_WORDS));

   always_comb begin
      o_region     = REGION_UNMAPPED;
      o_word_index = '0;
      if (w_rom_hit) begin
         o_region     = REGION_ROM;
         o_word_index = w_rom_off[IDX_W-1:0];
      end else if (w_ram_hit) begin
         o_region     = REGION_RAM;
         o_word_index = w_ram_off[IDX_W-1:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : memory_responder
//  Description : Memory bus target holding program ROM and data RAM; answers
//                read/write requests with MFC after a fixed latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_responder
   import mem_if_pkg::*;
#(
   parameter logic [31:0]              ROM_BASE  = 32'h0000_0000,
   parameter int                       ROM_WORDS = 256,
   parameter logic [31:0]              RAM_BASE  = 32'h0000_1000,
   parameter int                       RAM_WORDS = 256,
   parameter int                       LATENCY   = 2,
   // ROM contents, word i at bits [32*i +: 32]
   parameter logic [ROM_WORDS*32-1:0]  ROM_INIT  = (ROM_WORDS*32)'(default_rom_image())
) (
   input  logic        Clock,
   input  logic        MEM_Reset_n,
   input  logic [31:0] MEM_Address,
   input  logic [31:0] MEM_Data_In,
   input  logic [1:0]  MEM_r_w_z_z,
   output logic [31:0] MEM_Data_Out,
   output logic        MEM_MFC,
   output logic        MEM_ERROR
);

   localparam int c_rom_aw = $clog2(ROM_WORDS);
   localparam int c_ram_aw = $clog2(RAM_WORDS);
   localparam int c_idx_w  = (c_rom_aw > c_ram_aw) ? c_rom_aw : c_ram_aw;
   localparam int c_cnt_w  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);

   resp_state_e         r_state;
   resp_state_e         w_next_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [31:0]         r_addr;
   logic [1:0]          r_cmd;
   logic [31:0]         r_wdata;
   logic [31:0]         r_data;
   logic                r_err;
   logic [31:0]         r_ram [RAM_WORDS];

   logic                w_match;
   logic                w_capture;
   logic                w_access;
   logic                w_ram_we;
   logic [31:0]         w_acc_data;
   logic                w_acc_err;
   region_e             w_region;
   logic [c_idx_w-1:0]  w_idx;
   logic [c_rom_aw-1:0] w_rom_idx;
   logic [c_ram_aw-1:0] w_ram_idx;
   logic [31:0]         w_rom_word;

   mem_region_decoder #(
      .ROM_BASE  (ROM_BASE),
      .ROM_WORDS (ROM_WORDS),
      .RAM_BASE  (RAM_BASE),
      .RAM_WORDS (RAM_WORDS),
      .IDX_W     (c_idx_w)
   ) u_decoder (
      .i_addr       (r_addr),
      .o_region     (w_region),
      .o_word_index (w_idx)
   );

   assign w_rom_idx  = w_idx[c_rom_aw-1:0];
   assign w_ram_idx  = w_idx[c_ram_aw-1:0];
   assign w_rom_word = ROM_INIT[{w_rom_idx, 5'b0_0000} +: 32];

   // A live 1x command never equals a captured 00/01, so it also aborts.
   assign w_match = (MEM_Address == r_addr) && (MEM_r_w_z_z == r_cmd);

   always_comb begin
      w_next_state = r_state;
      w_capture    = 1'b0;
      w_access     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!MEM_r_w_z_z[1]) begin
               w_capture    = 1'b1;
               w_next_state = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!w_match) begin
               w_next_state = ST_IDLE;
            end else if (r_cnt == '0) begin
               w_access     = 1'b1;
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            if (!w_match) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      w_acc_data = '0;
      w_acc_err  = 1'b1;
      case (w_region)
         REGION_ROM: begin
            if (r_cmd == MEM_CMD_READ) begin
               w_acc_data = w_rom_word;
               w_acc_err  = 1'b0;
            end
         end
         REGION_RAM: begin
            w_acc_err = 1'b0;
            if (r_cmd == MEM_CMD_READ) begin
               w_acc_data = r_ram[w_ram_idx];
            end
         end
         default: begin
            w_acc_data = '0;
            w_acc_err  = 1'b1;
         end
      endcase
   end

   // Commit only on the completing edge, so an abort or reset never writes.
   assign w_ram_we = w_access && (w_region == REGION_RAM) && (r_cmd == MEM_CMD_WRITE);

   always_ff @(posedge Clock or negedge MEM_Reset_n) begin
      if (!MEM_Reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_cmd   <= MEM_CMD_READ;
         r_wdata <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (w_capture) begin
            r_addr  <= MEM_Address;
            r_cmd   <= MEM_r_w_z_z;
            r_wdata <= MEM_Data_In;
            r_cnt   <= c_cnt_load;
         end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
         end
         if (w_access) begin
            r_data <= w_acc_data;
            r_err  <= w_acc_err;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (w_ram_we) begin
         r_ram[w_ram_idx] <= r_wdata;
      end
   end

   assign MEM_MFC      = (r_state == ST_DONE);
   assign MEM_ERROR    = r_err && (r_state == ST_DONE);
   assign MEM_Data_Out = MEM_r_w_z_z[1] ? 32'bz : r_data;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_responder
//  Description : Directed bench for memory_responder (default parameters).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  cmd;
   tri1  [31:0] data_out;   // released bus floats to all ones
   logic        mfc;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [31:0] c_float = 32'hFFFF_FFFF;

   memory_responder dut (
      .Clock        (clk),
      .MEM_Reset_n  (rst_n),
      .MEM_Address  (addr),
      .MEM_Data_In  (wdata),
      .MEM_r_w_z_z  (cmd),
      .MEM_Data_Out (data_out),
      .MEM_MFC      (mfc),
      .MEM_ERROR    (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One full request with LATENCY=2, then bus release and return to idle.
   task automatic xact(input string tag, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_data, input logic exp_err);
      cmd = c; addr = a; wdata = d;
      tick(); check({tag, "/busy1"}, {31'b0, mfc}, 32'd0);
      tick(); check({tag, "/busy2"}, {31'b0, mfc}, 32'd0);
      tick(); check({tag, "/mfc"},   {31'b0, mfc}, 32'd1);
      check({tag, "/err"}, {31'b0, err}, {31'b0, exp_err});
      if (c == 2'b00) check({tag, "/data"}, data_out, exp_data);
      cmd = 2'b10;
      #1 check({tag, "/float"}, data_out, c_float);
      tick(); check({tag, "/idle"}, {31'b0, mfc}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; cmd = 2'b10; addr = '0; wdata = '0;
      tick(2);
      check("reset/mfc", {31'b0, mfc}, 32'd0);
      check("reset/err", {31'b0, err}, 32'd0);
      check("reset/float", data_out, c_float);
      cmd = 2'b00;
      #1 check("reset/data_reg", data_out, 32'd0);
      cmd = 2'b10;
      tick(); rst_n = 1'b1;
      tick();

      // ROM reads, including the last ROM word
      xact("rom_rd0",   2'b00, 32'h0000_0000, '0, 32'h1234_5678, 1'b0);
      xact("rom_rd_ff", 2'b00, 32'h0000_00FF, '0, 32'hC0DE_00FF, 1'b0);

      // RAM write then read back
      xact("ram_wr5", 2'b01, 32'h0000_1005, 32'hCAFE_F00D, '0, 1'b0);
      xact("ram_rd5", 2'b00, 32'h0000_1005, '0, 32'hCAFE_F00D, 1'b0);
      xact("ram_wr_last", 2'b01, 32'h0000_10FF, 32'h0BAD_CAFE, '0, 1'b0);
      xact("ram_rd_last", 2'b00, 32'h0000_10FF, '0, 32'h0BAD_CAFE, 1'b0);

      // ROM is write-protected
      xact("rom_wr10", 2'b01, 32'h0000_0010, 32'hDEAD_DEAD, '0, 1'b1);
      xact("rom_rd10", 2'b00, 32'h0000_0010, '0, 32'hC0DE_0010, 1'b0);

      // Unmapped, including just past both region ends
      xact("unm_1100", 2'b00, 32'h0000_1100, '0, 32'd0, 1'b1);
      xact("unm_ffff", 2'b00, 32'hFFFF_FFFF, '0, 32'd0, 1'b1);
      xact("unm_0100", 2'b00, 32'h0000_0100, '0, 32'd0, 1'b1);

      // Address change just before the completing edge aborts the write
      xact("ram_wr3_init", 2'b01, 32'h0000_1003, 32'h1111_1111, '0, 1'b0);
      cmd = 2'b01; addr = 32'h0000_1003; wdata = 32'hDEAD_BEEF;
      tick(); tick();
      check("abort/pre", {31'b0, mfc}, 32'd0);
      addr = 32'h0000_1004; wdata = 32'h5555_AAAA;
      tick(); check("abort/no_mfc", {31'b0, mfc}, 32'd0);
      tick(); check("abort/recap", {31'b0, mfc}, 32'd0);
      tick(); check("abort/busy", {31'b0, mfc}, 32'd0);
      tick(); check("abort/new_mfc", {31'b0, mfc}, 32'd1);
      check("abort/new_err", {31'b0, err}, 32'd0);
      cmd = 2'b10;
      tick();
      xact("abort_rd3", 2'b00, 32'h0000_1003, '0, 32'h1111_1111, 1'b0);
      xact("abort_rd4", 2'b00, 32'h0000_1004, '0, 32'h5555_AAAA, 1'b0);

      // Asynchronous reset while MFC is high
      cmd = 2'b00; addr = 32'h0000_0000;
      tick(3);
      check("rst_done/mfc_pre", {31'b0, mfc}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check("rst_done/mfc", {31'b0, mfc}, 32'd0);
      check("rst_done/data", data_out, 32'd0);
      cmd = 2'b10;
      tick(); rst_n = 1'b1;
      tick();

      // Asynchronous reset mid-BUSY of a write
      xact("ram_wr6_init", 2'b01, 32'h0000_1006, 32'h6666_6666, '0, 1'b0);
      cmd = 2'b01; addr = 32'h0000_1006; wdata = 32'h9999_9999;
      tick(); tick();
      #2 rst_n = 1'b0; cmd = 2'b10;
      #1 check("rst_busy/mfc", {31'b0, mfc}, 32'd0);
      check("rst_busy/err", {31'b0, err}, 32'd0);
      check("rst_busy/float", data_out, c_float);
      tick(2); rst_n = 1'b1;
      tick();
      xact("rst_busy_rd6", 2'b00, 32'h0000_1006, '0, 32'h6666_6666, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
